// File: rtl/ysyx22041405_mem_responder.sv
// Memory-side responder: one valid/ready request at a time, fixed or
// pseudo-random wait, then a valid/ready response carrying read data.
//
// Ports
//   clk        : sole clock, rising edge
//   rst        : asynchronous reset, active-low
//   req_valid  : request present
//   req_ready  : responder can accept (high only in IDLE)
//   req_addr   : byte address, word index = addr[DEPTH_LOG2+1:2]
//   req_wen    : 1 = write, 0 = read
//   req_wdata  : write data
//   req_wmask  : byte-lane write enables
//   rsp_valid  : response present
//   rsp_ready  : requester accepts the response
//   rsp_rdata  : read data (0 for write responses)
//
// Build option
//   RESP_RAND_DELAY_EN : adds lfsr[1:0] (0..3) to LATENCY per request,
//                        drawn from an 8-bit Fibonacci LFSR.
module ysyx22041405_mem_responder #(
    parameter int WIDTH      = 32,
    parameter int DEPTH_LOG2 = 10,
    parameter int LATENCY    = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [WIDTH-1:0]   req_addr,
    input  logic               req_wen,
    input  logic [WIDTH-1:0]   req_wdata,
    input  logic [WIDTH/8-1:0] req_wmask,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [WIDTH-1:0]   rsp_rdata
);

    localparam int NB    = WIDTH / 8;
    localparam int DEPTH = 1 << DEPTH_LOG2;

`ifdef RESP_RAND_DELAY_EN
    // LATENCY (<=15) + 3 needs five bits.
    localparam int CW = 5;
`else
    localparam int CW = 4;
`endif

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t                r_state;
    logic [CW-1:0]         r_cnt;
    logic [DEPTH_LOG2-1:0] r_idx;
    logic                  r_wen;
    logic                  r_req_ready;
    logic                  r_rsp_valid;
    logic [WIDTH-1:0]      r_rsp_rdata;
    logic [WIDTH-1:0]      r_mem [DEPTH];

    logic                  w_accept;
    logic [DEPTH_LOG2-1:0] w_idx;
    logic [CW-1:0]         w_delay;
    logic                  w_unused;

    assign w_accept = req_valid && r_req_ready;
    assign w_idx    = req_addr[DEPTH_LOG2+1:2];

    // Byte offset and bits above the index are don't-care: addresses wrap.
    assign w_unused = ^{req_addr[WIDTH-1:DEPTH_LOG2+2], req_addr[1:0]};

`ifdef RESP_RAND_DELAY_EN
    logic [7:0] r_lfsr;
    logic       w_fb;

    // x^8 + x^6 + x^5 + x^4 + 1, shifting toward the MSB.
    assign w_fb = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_lfsr <= 8'hA5;
        end else begin
            r_lfsr <= {r_lfsr[6:0], w_fb};
        end
    end

    assign w_delay = CW'(LATENCY) + {{(CW-2){1'b0}}, r_lfsr[1:0]};
`else
    assign w_delay = CW'(LATENCY);
`endif

    // Writes commit at acceptance, so a later read always sees them.
    always_ff @(posedge clk) begin
        for (int b = 0; b < NB; b++) begin
            if (w_accept && req_wen && req_wmask[b]) begin
                r_mem[w_idx][8*b +: 8] <= req_wdata[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_idx       <= '0;
            r_wen       <= 1'b0;
            r_req_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_idx       <= w_idx;
                        r_wen       <= req_wen;
                        r_req_ready <= 1'b0;
                        if (w_delay == '0) begin
                            // Zero delay: respond straight from the request.
                            r_state     <= S_RESP;
                            r_rsp_valid <= 1'b1;
                            r_rsp_rdata <= req_wen ? '0 : r_mem[w_idx];
                        end else begin
                            r_state <= S_WAIT;
                            r_cnt   <= w_delay - CW'(1);
                        end
                    end
                end
                S_WAIT: begin
                    if (r_cnt == '0) begin
                        r_state     <= S_RESP;
                        r_rsp_valid <= 1'b1;
                        r_rsp_rdata <= r_wen ? '0 : r_mem[r_idx];
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        r_state     <= S_IDLE;
                        r_rsp_valid <= 1'b0;
                        r_req_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign req_ready = r_req_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;

endmodule
